// File: rtl/uart_boot_loader_if.sv
// Purpose : BSRAM write port and load status of the UART boot loader.
// Latency : n/a (signal bundle only).
// Backpressure: none; the memory must accept one write per mem_wre pulse.
//
// Signals:
//   boot_mode  - 1 while loading (CPU hold / BSRAM address mux select)
//   mem_ce     - BSRAM chip enable
//   mem_wre    - BSRAM write enable, one-cycle pulse per word
//   mem_addr   - BSRAM write address
//   mem_din    - BSRAM write data
//   boot_error - sticky load-failure flag
//   word_count - words written in the current load
interface uart_boot_loader_if;
    logic        boot_mode;
    logic        mem_ce;
    logic        mem_wre;
    logic [10:0] mem_addr;
    logic [15:0] mem_din;
    logic        boot_error;
    logic [10:0] word_count;

    modport master (
        output boot_mode, mem_ce, mem_wre, mem_addr, mem_din, boot_error, word_count
    );

    modport slave (
        input boot_mode, mem_ce, mem_wre, mem_addr, mem_din, boot_error, word_count
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Purpose : receive a framed image over 8N1 UART and write it into BSRAM as 16-bit words.
// Latency : a word is written one cycle after its low byte's stop bit is sampled (plus 2-flop sync).
// Backpressure: none; the serial line cannot be stalled, so BSRAM must take every write pulse.
//
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   uart_rx    - asynchronous serial input, idle high
//   bus        - memory write port and status (uart_boot_loader_if.master)
//
// Frame: 0xA5, LEN_HI, LEN_LO, LEN x {HI, LO}, CHK (8-bit sum of data bytes).
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 234,
    parameter int MAX_WORDS    = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx,
    uart_boot_loader_if.master     bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [15:0]      MAX_LEN   = 16'(MAX_WORDS);

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic [7:0]       byte_dat_q, byte_dat_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_vld_d  = 1'b0;
        byte_dat_d  = byte_dat_q;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // Edge (not level) so a line held low after a bad stop bit
                // does not retrigger a byte every cycle.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;      // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_idx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB first
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_vld_d = 1'b1;
                        byte_dat_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_vld_q  <= 1'b0;
            byte_dat_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_vld_q  <= byte_vld_d;
            byte_dat_q  <= byte_dat_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser / loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        WAIT_HDR, LEN_H, LEN_L, DATA_H, DATA_L, CHECK, DONE, ERROR
    } ld_state_t;

    ld_state_t   ld_state_q, ld_state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  csum_q, csum_d;
    logic        boot_mode_q, boot_mode_d;
    logic        boot_error_q, boot_error_d;
    logic        mem_wre_q, mem_wre_d;
    logic [10:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [10:0] word_count_q, word_count_d;
    logic [15:0] len_cand;

    always_comb begin
        ld_state_d   = ld_state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        data_hi_d    = data_hi_q;
        csum_d       = csum_q;
        boot_mode_d  = boot_mode_q;
        boot_error_d = boot_error_q;
        mem_wre_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        // Count advances the cycle after the write pulse, so mem_addr
        // always shows the pre-increment value alongside mem_wre.
        word_count_d = mem_wre_q ? word_count_q + 11'd1 : word_count_q;
        len_cand     = {len_hi_q, byte_dat_q};

        if (frame_err_q && ld_state_q != WAIT_HDR && ld_state_q != DONE) begin
            ld_state_d   = ERROR;
            boot_error_d = 1'b1;
        end else if (byte_vld_q) begin
            case (ld_state_q)
                WAIT_HDR: begin
                    if (byte_dat_q == 8'hA5) ld_state_d = LEN_H;
                end
                LEN_H: begin
                    len_hi_d   = byte_dat_q;
                    ld_state_d = LEN_L;
                end
                LEN_L: begin
                    if (len_cand == 16'd0 || len_cand > MAX_LEN) begin
                        ld_state_d   = ERROR;
                        boot_error_d = 1'b1;
                    end else begin
                        len_d        = len_cand;
                        word_count_d = '0;
                        csum_d       = '0;
                        ld_state_d   = DATA_H;
                    end
                end
                DATA_H: begin
                    data_hi_d  = byte_dat_q;
                    csum_d     = csum_q + byte_dat_q;
                    ld_state_d = DATA_L;
                end
                DATA_L: begin
                    mem_din_d  = {data_hi_q, byte_dat_q};
                    mem_addr_d = word_count_q;
                    mem_wre_d  = 1'b1;
                    csum_d     = csum_q + byte_dat_q;
                    if ({5'd0, word_count_q} == len_q - 16'd1) begin
                        ld_state_d = CHECK;
                    end else begin
                        ld_state_d = DATA_H;
                    end
                end
                CHECK: begin
                    if (byte_dat_q == csum_q) begin
                        ld_state_d   = DONE;
                        boot_mode_d  = 1'b0;
                        boot_error_d = 1'b0;
                    end else begin
                        ld_state_d   = ERROR;
                        boot_error_d = 1'b1;
                    end
                end
                DONE: begin
                    // Terminal until reset: the CPU now owns the BSRAM.
                end
                ERROR: begin
                    if (byte_dat_q == 8'hA5) ld_state_d = LEN_H;
                end
                default: ld_state_d = WAIT_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q   <= WAIT_HDR;
            len_hi_q     <= '0;
            len_q        <= '0;
            data_hi_q    <= '0;
            csum_q       <= '0;
            boot_mode_q  <= 1'b1;
            boot_error_q <= 1'b0;
            mem_wre_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            word_count_q <= '0;
        end else begin
            ld_state_q   <= ld_state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            data_hi_q    <= data_hi_d;
            csum_q       <= csum_d;
            boot_mode_q  <= boot_mode_d;
            boot_error_q <= boot_error_d;
            mem_wre_q    <= mem_wre_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.boot_mode  = boot_mode_q;
    assign bus.mem_ce     = 1'b1;
    assign bus.mem_wre    = mem_wre_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.boot_error = boot_error_q;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Purpose : directed self-checking bench for uart_boot_loader at CLKS_PER_BIT = 4.
// Latency : n/a.
// Backpressure: n/a; every write pulse is logged by a monitor on the falling edge.
module tb_uart_boot_loader;
    localparam int CPB = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic uart_rx = 1'b1;

    uart_boot_loader_if bus ();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(2048)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [10:0] wr_addr[$];
    logic [15:0] wr_dat[$];
    int wre_run    = 0;
    int long_pulse = 0;
    int wre_idle   = 0;

    // Write log plus pulse-shape watchdog.
    always @(negedge clk) begin
        if (bus.mem_wre === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_dat.push_back(bus.mem_din);
            wre_run = wre_run + 1;
            if (wre_run > 1) long_pulse = long_pulse + 1;
            if (bus.boot_mode !== 1'b1) wre_idle = wre_idle + 1;
        end else begin
            wre_run = 0;
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_q(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_dat.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
    endtask

    task automatic check_reset_vals(input string tag);
        expect_eq({tag, "_mode"}, 32'(bus.boot_mode), 32'd1);
        expect_eq({tag, "_ce"},   32'(bus.mem_ce), 32'd1);
        expect_eq({tag, "_wre"},  32'(bus.mem_wre), 32'd0);
        expect_eq({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        expect_eq({tag, "_din"},  32'(bus.mem_din), 32'd0);
        expect_eq({tag, "_err"},  32'(bus.boot_error), 32'd0);
        expect_eq({tag, "_wc"},   32'(bus.word_count), 32'd0);
    endtask

    logic [7:0] fr[$];

    initial begin
        // Reset state, checked while rst_n is still low.
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Two-word load: checksum 00+A1+00+78 = 0x119 -> 0x19.
        fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'h19};
        send_q(fr);
        expect_eq("ok_nwr",   32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            expect_eq("ok_a0", 32'(wr_addr[0]), 32'h000);
            expect_eq("ok_d0", 32'(wr_dat[0]),  32'h00A1);
            expect_eq("ok_a1", 32'(wr_addr[1]), 32'h001);
            expect_eq("ok_d1", 32'(wr_dat[1]),  32'h0078);
        end
        expect_eq("ok_wc",   32'(bus.word_count), 32'd2);
        expect_eq("ok_mode", 32'(bus.boot_mode), 32'd0);
        expect_eq("ok_err",  32'(bus.boot_error), 32'd0);

        // Once DONE, another frame is ignored entirely.
        fr = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'h66, 8'hBB};
        send_q(fr);
        expect_eq("done_nwr",  32'(wr_addr.size()), 32'd2);
        expect_eq("done_mode", 32'(bus.boot_mode), 32'd0);

        // Bad checksum, then a correct retry clears the error.
        do_reset();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'h20};
        send_q(fr);
        expect_eq("bchk_nwr",  32'(wr_addr.size()), 32'd2);
        expect_eq("bchk_err",  32'(bus.boot_error), 32'd1);
        expect_eq("bchk_mode", 32'(bus.boot_mode), 32'd1);
        fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA1, 8'h00, 8'h78, 8'h19};
        send_q(fr);
        expect_eq("retry_nwr",  32'(wr_addr.size()), 32'd4);
        expect_eq("retry_mode", 32'(bus.boot_mode), 32'd0);
        expect_eq("retry_err",  32'(bus.boot_error), 32'd0);
        expect_eq("retry_wc",   32'(bus.word_count), 32'd2);

        // Junk before header is ignored.
        do_reset();
        fr = '{8'h3C, 8'h11, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
        send_q(fr);
        expect_eq("junk_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            expect_eq("junk_a0", 32'(wr_addr[0]), 32'h000);
            expect_eq("junk_d0", 32'(wr_dat[0]),  32'h1234);
        end
        expect_eq("junk_mode", 32'(bus.boot_mode), 32'd0);

        // Oversized length (2049).
        do_reset();
        fr = '{8'hA5, 8'h08, 8'h01};
        send_q(fr);
        expect_eq("big_err",  32'(bus.boot_error), 32'd1);
        expect_eq("big_mode", 32'(bus.boot_mode), 32'd1);
        expect_eq("big_nwr",  32'(wr_addr.size()), 32'd0);

        // Zero length.
        do_reset();
        fr = '{8'hA5, 8'h00, 8'h00};
        send_q(fr);
        expect_eq("zero_err", 32'(bus.boot_error), 32'd1);
        expect_eq("zero_nwr", 32'(wr_addr.size()), 32'd0);

        // Framing error on the low data byte.
        do_reset();
        fr = '{8'hA5, 8'h00, 8'h01, 8'h12};
        send_q(fr);
        send_byte(8'h34, 1'b0);
        repeat (12) @(negedge clk);
        expect_eq("ferr_err",  32'(bus.boot_error), 32'd1);
        expect_eq("ferr_nwr",  32'(wr_addr.size()), 32'd0);
        expect_eq("ferr_mode", 32'(bus.boot_mode), 32'd1);

        // Two-cycle glitch mid-load must not produce a byte or a framing error.
        do_reset();
        fr = '{8'hA5, 8'h00, 8'h01};
        send_q(fr);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        fr = '{8'h12, 8'h34, 8'h46};
        send_q(fr);
        expect_eq("glit_nwr",  32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1)
            expect_eq("glit_d0", 32'(wr_dat[0]), 32'h1234);
        expect_eq("glit_mode", 32'(bus.boot_mode), 32'd0);
        expect_eq("glit_err",  32'(bus.boot_error), 32'd0);

        // Reset after first data byte abandons the load.
        do_reset();
        fr = '{8'hA5, 8'h00, 8'h02, 8'h00};
        send_q(fr);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("mid");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        repeat (20) @(negedge clk);
        expect_eq("mid_nopart", 32'(wr_addr.size()), 32'd0);
        fr = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46};
        send_q(fr);
        expect_eq("mid_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            expect_eq("mid_a0", 32'(wr_addr[0]), 32'h000);
            expect_eq("mid_d0", 32'(wr_dat[0]),  32'h1234);
        end
        expect_eq("mid_mode", 32'(bus.boot_mode), 32'd0);

        // Pulse shape over the whole run.
        expect_eq("wre_width", 32'(long_pulse), 32'd0);
        expect_eq("wre_idle",  32'(wre_idle), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk cycles per UART bit (27 MHz / 115200).
REQ-002 Parameter MAX_WORDS, default 2048, BSRAM depth in 16-bit words.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 boot_mode  output  1  1 while loading; drives CPU hold and BSRAM address mux.
REQ-007 mem_ce  output  1  BSRAM chip enable.
REQ-008 mem_wre  output  1  BSRAM write enable, one-cycle pulse per word.
REQ-009 mem_addr  output  11  BSRAM write address.
REQ-010 mem_din  output  16  BSRAM write data.
REQ-011 boot_error  output  1  sticky load failure flag.
REQ-012 word_count  output  11  words written in the current load.

Function
REQ-013 Synchronise uart_rx through 2 flops before any use.
REQ-014 RX: falling edge in idle starts a byte; start bit re-sampled at CLKS_PER_BIT/2, high -> return to idle silently.
REQ-015 RX: 8 data bits sampled every CLKS_PER_BIT from start-bit midpoint; stop bit sampled likewise.
REQ-016 RX: stop bit 1 -> one-cycle internal byte_valid pulse with the byte; stop bit 0 -> framing error, no byte_valid.
REQ-017 Frame: 0xA5, LEN_HI, LEN_LO, then LEN words (HI byte, then LO byte), then CHK; CHK = 8-bit sum mod 256 of all data bytes (not header or length).
REQ-018 FSM states: WAIT_HDR, LEN_H, LEN_L, DATA_H, DATA_L, CHECK, DONE, ERROR.
REQ-019 WAIT_HDR: 0xA5 -> LEN_H; any other byte ignored.
REQ-020 LEN_L: LEN = {LEN_HI, LEN_LO}; LEN = 0 or LEN > MAX_WORDS -> ERROR; else word_count cleared, checksum cleared, -> DATA_H.
REQ-021 DATA_H: latch high byte -> DATA_L.
REQ-022 DATA_L: on byte, mem_din = {hi, lo}, mem_addr = word_count, mem_wre = 1 for exactly the next cycle, then word_count increments.
REQ-023 After write of word LEN-1 -> CHECK; otherwise -> DATA_H.
REQ-024 Addresses wrap at 11 bits; with MAX_WORDS = 2048 last address is 0x7FF, never rolls over within a load.
REQ-025 CHECK: byte == checksum -> DONE; mismatch -> ERROR.
REQ-026 DONE: boot_mode = 0, mem_wre = 0; further RX bytes ignored until reset.
REQ-027 ERROR: boot_error = 1, boot_mode stays 1; byte 0xA5 -> LEN_H (boot_error held until DONE of a later load, then cleared).
REQ-028 Framing error in any state other than WAIT_HDR, DONE -> ERROR.
REQ-029 mem_ce = 1 at all times after reset.
REQ-030 mem_wre never asserted outside DATA_L write cycle; never while boot_mode = 0.
REQ-031 boot_mode falls the cycle after CHK accepted; no glitch high again until reset.

Reset
REQ-032 rst_n low, any state: boot_mode = 1, mem_ce = 1, mem_wre = 0, mem_addr = 0, mem_din = 0, boot_error = 0, word_count = 0, FSM = WAIT_HDR, RX idle.
REQ-033 Reset mid-byte or mid-load abandons it; no partial write issued after rst_n rises.

Verification (CLKS_PER_BIT = 4)
REQ-034 Send A5 00 02 00 A1 00 78 CHK=19 -> writes 0x00A1 at 0, 0x0078 at 1, word_count = 2, boot_mode = 0, boot_error = 0.
REQ-035 Same frame with CHK = 0x20 -> both words written, boot_error = 1, boot_mode = 1; resend correct frame -> boot_mode = 0, boot_error = 0.
REQ-036 Send 3C 11 then valid 1-word frame A5 00 01 12 34 46 -> junk ignored, 0x1234 written at 0, boot done.
REQ-037 Send A5 08 01 -> ERROR (LEN 2049 > MAX_WORDS), no mem_wre pulse.
REQ-038 Byte with stop bit 0 during DATA_L -> ERROR, no write for that word; 2-cycle low glitch on idle line -> no byte produced.
REQ-039 Assert rst_n low after first data byte of a load -> all outputs at reset values, subsequent valid frame loads correctly from address 0.
